imem_arbiter: RTL and testbench

Shares one single-ported instruction memory between the instruction-fetch unit and the program loader/debug port. Arbitrates round-robin, issues one memory transaction at a time, waits a fixed memory latency, then returns read data to the winning requester. Sits between fetch/loader logic and the instruction RAM, replacing direct fetch-to-memory wiring when the memory is synchronous or multi-cycle.

---
 rtl/imem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_imem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-ported instruction memory between the instruction-fetch
// unit and the program loader/debug port. A round-robin arbiter grants one
// requester at a time. The grant, the requester's ready and the memory strobe
// are all driven combinationally in the same IDLE cycle. A down-counter then
// waits out the fixed memory latency. The read data (or zero for a loader
// write) is registered into the winner's rdata register, and rvalid pulses
// for one cycle.
//
// Parameters
//   ADDR_WIDTH   word address width (4-byte aligned words)
//   DATA_WIDTH   data word width
//   MEM_LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr           fetch read request, held until if_ready
//   if_ready                 fetch request accepted this cycle
//   if_rvalid/if_rdata       one-cycle completion pulse and held read data
//   ld_req/ld_we/ld_addr/
//   ld_wdata                 loader request (write when ld_we=1), held until
//                            ld_ready
//   ld_ready                 loader request accepted this cycle
//   ld_rvalid/ld_rdata       completion pulse; ld_rdata is 0 after a write
//   mem_en/mem_we/mem_addr/
//   mem_wdata                memory access strobe and command
//   mem_rdata                memory read data, valid MEM_LATENCY cycles after
//                            the mem_en cycle
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Counter is wide enough for the full legal latency range 1..15.
  localparam int unsigned     CNT_W   = 4;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LATENCY);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_id_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  req_id_e               winner_q;    // requester owning the transaction in flight
  req_id_e               last_q;      // round-robin pointer: last requester granted
  logic                  wr_q;        // transaction in flight is a loader write
  logic                  if_rvalid_q;
  logic                  ld_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] ld_rdata_q;

  // Combinational grant decode (next winner and whether anyone is accepted).
  logic                  grant_if;
  logic                  grant_ld;
  logic                  accept;
  req_id_e               winner_d;
  logic                  wr_d;

  // ---------------------------------------------------------------------------
  // Arbitration and memory command. Only IDLE cycles outside reset can grant.
  // On a tie the requester that was not granted last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    grant_if  = 1'b0;
    grant_ld  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!rst && state_q == S_IDLE) begin
      if (if_req && ld_req) begin
        if (last_q == REQ_LD) grant_if = 1'b1;
        else                  grant_ld = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (ld_req) begin
        grant_ld = 1'b1;
      end
    end

    accept   = grant_if | grant_ld;
    winner_d = grant_ld ? REQ_LD : REQ_IF;
    wr_d     = grant_ld & ld_we;

    if (grant_if) begin
      mem_addr = if_addr;
    end else if (grant_ld) begin
      mem_addr = ld_addr;
      // Write data only reaches the memory for an actual write.
      if (ld_we) mem_wdata = ld_wdata;
    end

    if_ready = grant_if;
    ld_ready = grant_ld;
    mem_en   = accept;
    mem_we   = wr_d;
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM, latency counter and registered responses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      winner_q    <= REQ_IF;
      last_q      <= REQ_LD;         // fetch wins the first tie after reset
      wr_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      // NOTE: the rdata holding registers are ordinary datapath flops, not a
      // memory array, so they are cleared by reset like everything else.
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            winner_q <= winner_d;
            last_q   <= winner_d;
            wr_q     <= wr_d;
            cnt_q    <= LAT_CNT;
            state_q  <= S_WAIT;
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          // cnt_q==1 marks the cycle in which mem_rdata is valid.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            if (winner_q == REQ_LD) begin
              ld_rvalid_q <= 1'b1;
              ld_rdata_q  <= wr_q ? '0 : mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Drives the arbiter with fetch and loader requesters. A latency-accurate
// memory model sits on the memory side. It presents valid data only during
// the one cycle the arbiter is supposed to sample it.
//
// Expected behaviour is computed per cycle from a transaction-level model.
// That model tracks the cycle number at which the arbiter is free again, the
// last requester granted, and a queue of responses due at absolute cycle
// numbers. A shadow memory supplies the expected read data.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ld_req = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_ready, ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  imem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ld_req   (ld_req),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_ready (ld_ready),
    .ld_rvalid(ld_rvalid),
    .ld_rdata (ld_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: read data is valid only in the cycle LAT after the access.
  // It shows the inverted word in every other cycle.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_hold = '0;
  int            rd_cnt  = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
      else begin
        rd_hold <= mem[mem_addr[5:0]];
        rd_cnt  <= LAT;
      end
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign mem_rdata = (rd_cnt == 1) ? rd_hold : ~rd_hold;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int            cyc;
    bit            ld;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         resp_q[$];
  logic [DW-1:0] ref_mem [64];
  int            free_at = 0;
  bit            last_ld = 1'b1;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_ld_rdata = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            n_if_dut = 0;
  int            n_ld_dut = 0;

  // Requester state
  bit if_pend = 1'b0;
  bit ld_pend = 1'b0;
  bit acc_if  = 1'b0;
  bit acc_ld  = 1'b0;
  bit hold_rst = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Evaluate one cycle (called at the falling edge).
  task automatic eval_cycle();
    bit    exp_if_rv = 1'b0;
    bit    exp_ld_rv = 1'b0;
    bit    g_if = 1'b0;
    bit    g_ld = 1'b0;
    resp_t r;

    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      r = resp_q.pop_front();
      if (r.ld) begin exp_ld_rv = 1'b1; exp_ld_rdata = r.data; end
      else      begin exp_if_rv = 1'b1; exp_if_rdata = r.data; end
    end
    check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    check("ld_rvalid", 32'(ld_rvalid), 32'(exp_ld_rv));
    check("if_rdata",  if_rdata, exp_if_rdata);
    check("ld_rdata",  ld_rdata, exp_ld_rdata);

    if (if_ready) n_if_dut++;
    if (ld_ready) n_ld_dut++;
    check("one_ready", 32'(if_ready & ld_ready), 32'd0);

    // The arbiter is free once the previous response is due; ties go to
    // whichever requester was not granted last.
    if (!rst && cyc >= free_at) begin
      if (if_req && ld_req) begin
        if (last_ld) g_if = 1'b1; else g_ld = 1'b1;
      end else if (if_req) g_if = 1'b1;
      else if (ld_req)     g_ld = 1'b1;
    end

    check("if_ready", 32'(if_ready), 32'(g_if));
    check("ld_ready", 32'(ld_ready), 32'(g_ld));
    check("mem_en",   32'(mem_en),   32'(g_if | g_ld));
    check("mem_we",   32'(mem_we),   32'(g_ld & ld_we));

    if (g_if) begin
      check("mem_addr_if",  32'(mem_addr), 32'(if_addr));
      check("mem_wdata_if", mem_wdata, 32'd0);
      resp_q.push_back('{cyc + LAT + 1, 1'b0, ref_mem[if_addr[5:0]]});
      last_ld = 1'b0;
      free_at = cyc + LAT + 1;
    end else if (g_ld) begin
      check("mem_addr_ld", 32'(mem_addr), 32'(ld_addr));
      if (ld_we) begin
        check("mem_wdata_ld", mem_wdata, ld_wdata);
        ref_mem[ld_addr[5:0]] = ld_wdata;
        resp_q.push_back('{cyc + LAT + 1, 1'b1, 32'd0});
      end else begin
        resp_q.push_back('{cyc + LAT + 1, 1'b1, ref_mem[ld_addr[5:0]]});
      end
      last_ld = 1'b1;
      free_at = cyc + LAT + 1;
    end else if (!rst && cyc < free_at) begin
      check("mem_addr_wait",  32'(mem_addr), 32'd0);
      check("mem_wdata_wait", mem_wdata, 32'd0);
    end

    acc_if = g_if;
    acc_ld = g_ld;

    // Reset abandons anything in flight and clears the response registers
    // from the next cycle on.
    if (rst) begin
      resp_q.delete();
      exp_if_rdata = '0;
      exp_ld_rdata = '0;
      last_ld      = 1'b1;
      free_at      = cyc + 1;
    end
  endtask

  // One clock cycle: update the requesters after the rising edge, then
  // evaluate at the falling edge.
  task automatic step(input int p_if, input int p_ld, input int p_drop, input int p_rst);
    @(posedge clk);
    #1;
    if (acc_if) if_pend = 1'b0;
    if (acc_ld) ld_pend = 1'b0;
    if (if_pend && $urandom_range(99) < p_drop) if_pend = 1'b0;
    if (ld_pend && $urandom_range(99) < p_drop) ld_pend = 1'b0;
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1'b1;
      if_addr = AW'($urandom_range(63));
    end
    if (!ld_pend && $urandom_range(99) < p_ld) begin
      ld_pend  = 1'b1;
      ld_we    = 1'($urandom_range(1));
      ld_addr  = AW'($urandom_range(63));
      ld_wdata = $urandom;
    end
    rst    = hold_rst || ($urandom_range(999) < p_rst);
    if_req = if_pend;
    ld_req = ld_pend;
    @(negedge clk);
    cyc++;
    eval_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    // Reset held two cycles with both requesters asking.
    if_pend = 1'b1; if_addr = AW'(5);
    ld_pend = 1'b1; ld_we = 1'b0; ld_addr = AW'(7);
    hold_rst = 1'b1;
    repeat (2) step(0, 0, 0, 0);
    hold_rst = 1'b0;

    // Fetch wins the first tie. Afterwards fetch requests arrive continuously.
    repeat (20) step(100, 0, 0, 0);

    // Continuous contention: grants must alternate.
    repeat (40) step(100, 100, 0, 0);

    // Drain, then a loader write to 0x10 followed by a fetch of 0x10.
    repeat (12) step(0, 0, 0, 0);
    ld_pend = 1'b1; ld_we = 1'b1; ld_addr = AW'('h10); ld_wdata = 32'h1234_5678;
    step(0, 0, 0, 0);
    if_pend = 1'b1; if_addr = AW'('h10);
    repeat (12) step(0, 0, 0, 0);

    // Random traffic with dropped requests and occasional resets.
    repeat (3000) step(60, 40, 10, 15);
    repeat (12) step(0, 0, 0, 0);

    check("fetch_granted", 32'(n_if_dut > 0), 32'd1);
    check("loader_granted", 32'(n_ld_dut > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
